serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell and a carry flip-flop.

---
 rtl/serial_adder_pkg.sv | 27 ++
 rtl/serial_adder_if.sv | 45 ++++
 rtl/serial_adder_fa_cell.sv | 18 +
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_t      : FSM encoding (IDLE=0, RUN=1, DONE=2; 3 is unused and
//                    recovers to IDLE)
//   - WIDTH_DEFAULT: default operand width
//   - ovf_bit()    : signed-overflow rule (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DONE   = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  // Two's-complement overflow occurs when the carry entering the sign bit
  // differs from the carry leaving it.
  function automatic logic ovf_bit(input logic carry_into_msb,
                                   input logic carry_out_of_msb);
    return carry_into_msb ^ carry_out_of_msb;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Operand / result handshake bundle for serial_adder.
//   Operand side : in_valid, in_ready, A, B, Cin
//   Result side  : out_valid, out_ready, Sum, Carry (+ Ovf when
//                  SERIAL_ADDER_OVF_EN is defined)
//   master : the environment (drives operands, accepts results)
//   slave  : the adder
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry, Ovf
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry
  );
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Purely combinational 1-bit full adder; the only arithmetic in the design.
//   Ports: a, b, ci (inputs); s = a^b^ci, co = a&b | ci&(a^b) (outputs)
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p_s;

  assign p_s = a ^ b;
  assign s   = p_s ^ ci;
  assign co  = (a & b) | (ci & p_s);
endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop
//   add one bit per clock, LSB first, then present {Carry, Sum} through a
//   valid/ready handshake.
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : serial_adder_if.slave (in_valid/in_ready/A/B/Cin,
//             out_valid/out_ready/Sum/Carry[/Ovf])
//
//   Configuration
//     SERIAL_ADDER_OVF_EN : adds the Ovf (signed overflow) result bit.
//
//   Timing
//     Accept edge -> WIDTH RUN cycles -> DONE. out_valid is raised on the
//     first DONE edge, so it rises WIDTH+1 clocks after the accept edge.
//     Sum/Carry only change on the final RUN edge and therefore stay frozen
//     through DONE and after the handshake until the next result.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;       // running carry between bit slices
  logic             carry_out_r;   // published carry-out
  logic [CW-1:0]    cnt_r;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_r;
`endif

  logic             fa_s_s;
  logic             fa_co_s;
  logic [WIDTH:0]   sum_cat_s;
  logic [WIDTH-1:0] sum_next_s;

  fa_cell u_fa_cell (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  // Concatenate-then-slice keeps this legal for WIDTH == 1.
  assign sum_cat_s  = {fa_s_s, sum_sh_r};
  assign sum_next_s = sum_cat_s[WIDTH:1];

  // Control FSM plus the serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      cnt_r       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_sh_r     <= bus.A;
            b_sh_r     <= bus.B;
            carry_r    <= bus.Cin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= S_RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end

        S_RUN: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          sum_sh_r <= sum_next_s;
          carry_r  <= fa_co_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            // Final slice: carry_r is the carry into the MSB here.
            sum_r       <= sum_next_s;
            carry_out_r <= fa_co_s;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r       <= ovf_bit(carry_r, fa_co_s);
`endif
            state_r     <= S_DONE;
          end else begin
            state_r     <= S_RUN;
          end
        end

        S_DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Sum       = sum_r;
  assign bus.Carry     = carry_out_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.Ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder: a WIDTH=8 instance (vector table,
//   backpressure, mid-run reset, random jobs) and a WIDTH=1 instance
//   (exhaustive full-adder truth table). Expected results go into a queue
//   when a job is accepted and are popped when out_valid rises.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
    exp_t e;
    logic [8:0] tot;
    tot     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    e.sum   = tot[7:0];
    e.carry = tot[8];
    e.ovf   = (a[7] == b[7]) && (tot[7] != a[7]);
    return e;
  endfunction

  // One job on the WIDTH=8 instance: accept, latency, result, stalls, handshake.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input exp_t e, input int stall);
    int   t;
    exp_t got;
    t = 0;
    while (bus8.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready stayed %b", bus8.in_ready);
      return;
    end
    bus8.A = a; bus8.B = b; bus8.Cin = cin; bus8.in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.Cin = 1'($urandom);
    chk("in_ready_after_accept", {31'd0, bus8.in_ready}, 32'd0);
    t = 0;
    while (bus8.out_valid !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("latency", t, 32'd9);
    if (bus8.out_valid !== 1'b1) begin
      void'(sb.pop_front());
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty on out_valid, got %0d entries", sb.size());
      return;
    end
    got = sb.pop_front();
    chk("sum", {24'd0, bus8.Sum}, {24'd0, got.sum});
    chk("carry", {31'd0, bus8.Carry}, {31'd0, got.carry});
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {31'd0, bus8.Ovf}, {31'd0, got.ovf});
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", {31'd0, bus8.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bus8.in_ready}, 32'd0);
      chk("stall_sum", {24'd0, bus8.Sum}, {24'd0, got.sum});
      chk("stall_carry", {31'd0, bus8.Carry}, {31'd0, got.carry});
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("post_hs_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    chk("post_hs_sum_kept", {24'd0, bus8.Sum}, {24'd0, got.sum});
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    int   t;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    bus8.in_valid = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00; bus8.Cin = 1'b0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.A = 1'b0;  bus1.B = 1'b0;  bus1.Cin = 1'b0; bus1.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("rst_sum", {24'd0, bus8.Sum}, 32'd0);
    chk("rst_carry", {31'd0, bus8.Carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      e.sum = vecs[i].sum; e.carry = vecs[i].carry; e.ovf = vecs[i].ovf;
      run_job(vecs[i].a, vecs[i].b, vecs[i].cin, e, 0);
    end

    // Backpressure: 5 stalled cycles in DONE
    e.sum = 8'hFF; e.carry = 1'b1; e.ovf = 1'b0;
    run_job(8'hFF, 8'hFF, 1'b1, e, 5);

    // Reset on the 4th RUN cycle aborts the job
    bus8.A = 8'h5A; bus8.B = 8'h3C; bus8.Cin = 1'b1; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    chk("midrun_rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("midrun_rst_sum", {24'd0, bus8.Sum}, 32'd0);
    chk("midrun_rst_carry", {31'd0, bus8.Carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    e.sum = 8'h46; e.carry = 1'b0; e.ovf = 1'b0;
    run_job(8'h12, 8'h34, 1'b0, e, 0);

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] want;
      v    = 3'(i);
      want = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      bus1.A = v[2]; bus1.B = v[1]; bus1.Cin = v[0]; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      t = 0;
      while (bus1.out_valid !== 1'b1 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      chk("w1_latency", t, 32'd2);
      chk("w1_result", {30'd0, bus1.Carry, bus1.Sum}, {30'd0, want});
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      chk("w1_in_ready", {31'd0, bus1.in_ready}, 32'd1);
    end

    // Random jobs with random result stalls
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e  = model(ra, rb, rc);
      run_job(ra, rb, rc, e, $urandom_range(0, 3));
    end

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
